// File: rtl/fir_pkg.sv
// Shared types and helpers for the multichannel low-pass FIR.
// Coefficient sets are passed as a fixed-size packed table; only the first TAPS entries are used.
package fir_pkg;

  localparam int FIR_MAX_TAPS   = 1024;
  localparam int FIR_COEF_MAX_W = 32;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    MAC   = 2'd2,
    HOLD  = 2'd3
  } fir_state_t;

  typedef logic [FIR_MAX_TAPS-1:0][FIR_COEF_MAX_W-1:0] coef_arr_t;

  // Unit impulse: unity gain once the accumulator is shifted right by out_shift.
  function automatic coef_arr_t FIR_DEFAULT_COEF(int out_shift);
    coef_arr_t c;
    c    = '0;
    c[0] = FIR_COEF_MAX_W'(1) << out_shift;
    return c;
  endfunction

  function automatic int fir_ch_w(int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int fir_acc_w(int data_w, int coef_w, int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_delay_ram.sv
// Single-port delay-line storage for all channels, one-cycle registered read.
// No reset on the array or read register so it maps onto block RAM.
module fir_delay_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/lowpass_fir_mc.sv
// Time-multiplexed multichannel FIR: one MAC per cycle over a shared delay RAM.
// Build option: define LOWPASS_FIR_SATURATE_EN to clamp the output to 32-bit signed range.
//
// state | meaning
// CLEAR | zero every delay entry, one per cycle, after reset
// IDLE  | ready for an input beat
// MAC   | TAPS reads through the channel ring plus two pipeline drain cycles
// HOLD  | result presented until the consumer takes it
module lowpass_fir_mc
  import fir_pkg::*;
#(
  parameter int        DATA_W    = 24,
  parameter int        COEF_W    = 24,
  parameter int        TAPS      = 128,
  parameter int        CHANNELS  = 4,
  parameter int        OUT_SHIFT = 16,
  parameter coef_arr_t COEF      = FIR_DEFAULT_COEF(OUT_SHIFT),
  localparam int       CH_W      = fir_ch_w(CHANNELS),
  localparam int       ACC_W     = fir_acc_w(DATA_W, COEF_W, TAPS)
) (
  input  logic            s_axis_aclk,
  input  logic            s_axis_arstn,
  input  logic [31:0]     s_axis_tdata,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  input  logic [CH_W-1:0] s_axis_tuser,
  output logic [31:0]     m_axis_tdata,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic [CH_W-1:0] m_axis_tuser
);

  localparam int DEPTH  = CHANNELS * TAPS;
  localparam int AW     = $clog2(DEPTH);
  localparam int PTR_W  = $clog2(TAPS);
  localparam int CNT_W  = $clog2(TAPS + 3);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int IDX_W  = $clog2(FIR_MAX_TAPS);
  localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);

  fir_state_t state, state_nxt;

  logic [AW-1:0]    clr_cnt;
  logic [PTR_W-1:0] head [CHANNELS];
  logic [PTR_W-1:0] head_sel;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] tap_idx;
  logic [CH_W-1:0]  ch_q;
  logic [CNT_W-1:0] mac_cnt;

  logic s_hs, ch_ok, accept, m_hs, mac_done, issuing;

  logic              ram_en, ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  logic signed [DATA_W-1:0] sample;
  logic signed [DATA_W-1:0] rd_s;
  logic signed [COEF_W-1:0] coef_q;
  logic signed [PROD_W-1:0] prod;
  logic                     rd_vld, prod_vld;
  logic signed [ACC_W-1:0]  acc, acc_sh;
  logic [31:0]              out_word;

  function automatic logic [AW-1:0] ram_index(logic [CH_W-1:0] ch, logic [PTR_W-1:0] ptr);
    return AW'(ch) * AW'(TAPS) + AW'(ptr);
  endfunction

  assign sample        = s_axis_tdata[DATA_W-1:0];
  assign s_axis_tready = (state == IDLE) && !m_axis_tvalid;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign ch_ok         = {1'b0, s_axis_tuser} < CH_LIM;
  assign accept        = s_hs && ch_ok;
  assign m_hs          = m_axis_tvalid && m_axis_tready;
  assign mac_done      = (mac_cnt == '0);

  generate
    if (DATA_W < 32) begin : g_tdata_hi
      logic unused_tdata_hi;
      assign unused_tdata_hi = ^s_axis_tdata[31:DATA_W];
    end
  endgenerate

  always_comb begin
    head_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s_axis_tuser == CH_W'(i)) head_sel = head[i];
    end
  end

  // FSM: state register
  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) state <= CLEAR;
    else               state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_cnt == '0) state_nxt = IDLE;
      IDLE:    if (accept)        state_nxt = MAC;
      MAC:     if (mac_done)      state_nxt = HOLD;
      HOLD:    if (m_hs)          state_nxt = IDLE;
      default:                    state_nxt = CLEAR;
    endcase
  end

  // FSM: outputs (delay RAM port and MAC issue strobe)
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    issuing   = 1'b0;
    case (state)
      CLEAR: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = clr_cnt;
      end
      IDLE: begin
        if (accept) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = ram_index(s_axis_tuser, head_sel);
          ram_wdata = sample;
        end
      end
      MAC: begin
        issuing  = (mac_cnt > CNT_W'(2));
        ram_en   = issuing;
        ram_addr = ram_index(ch_q, rd_ptr);
      end
      default: ;
    endcase
  end

  fir_delay_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W),
    .AW    (AW)
  ) u_ram (
    .clk   (s_axis_aclk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn)                         clr_cnt <= AW'(DEPTH - 1);
    else if (state == CLEAR && clr_cnt != '0)  clr_cnt <= clr_cnt - AW'(1);
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      for (int i = 0; i < CHANNELS; i++) head[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (s_axis_tuser == CH_W'(i))
          head[i] <= (head[i] == PTR_W'(TAPS - 1)) ? '0 : head[i] + PTR_W'(1);
      end
    end
  end

  // Read pointer walks backwards from the newest sample, wrapping inside the channel ring.
  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      mac_cnt <= '0;
      tap_idx <= '0;
      rd_ptr  <= '0;
      ch_q    <= '0;
    end else if (accept) begin
      mac_cnt <= CNT_W'(TAPS + 2);
      tap_idx <= '0;
      rd_ptr  <= head_sel;
      ch_q    <= s_axis_tuser;
    end else if (state == MAC) begin
      if (!mac_done) mac_cnt <= mac_cnt - CNT_W'(1);
      if (issuing) begin
        tap_idx <= tap_idx + PTR_W'(1);
        rd_ptr  <= (rd_ptr == '0) ? PTR_W'(TAPS - 1) : rd_ptr - PTR_W'(1);
      end
    end
  end

  assign rd_s = ram_rdata;

  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      coef_q   <= '0;
      prod     <= '0;
      rd_vld   <= 1'b0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      rd_vld   <= issuing;
      prod_vld <= rd_vld;
      if (issuing) coef_q <= COEF[IDX_W'(tap_idx)][COEF_W-1:0];
      if (rd_vld)  prod   <= PROD_W'(rd_s) * PROD_W'(coef_q);
      if (m_hs)          acc <= '0;
      else if (prod_vld) acc <= acc + ACC_W'(prod);
    end
  end

  assign acc_sh = acc >>> OUT_SHIFT;

`ifdef LOWPASS_FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2147483647);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    if (acc_sh > SAT_MAX)      out_word = 32'h7FFF_FFFF;
    else if (acc_sh < SAT_MIN) out_word = 32'h8000_0000;
    else                       out_word = acc_sh[31:0];
  end
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc_sh[ACC_W-1:32];
  assign out_word      = acc_sh[31:0];
`endif

  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
    end else if (state == MAC && mac_done) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= out_word;
      m_axis_tuser  <= ch_q;
    end else if (m_hs) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: doc/lowpass_fir_mc.md
LOWPASS_FIR_MC -- requirements
Module: lowpass_fir_mc

Interface
- REQ-001 Parameter DATA_W, 24: input sample width, taken from s_axis_tdata[DATA_W-1:0], signed.
- REQ-002 Parameter COEF_W, 24: signed coefficient width.
- REQ-003 Parameter TAPS, 128: filter length, 2..1024.
- REQ-004 Parameter CHANNELS, 4: independent channels, 1..16.
- REQ-005 Parameter OUT_SHIFT, 16: arithmetic right shift applied to the accumulator.
- REQ-006 Parameter COEF, default fir_pkg::FIR_DEFAULT_COEF: TAPS signed coefficients, index 0 applied to the newest sample. The default is a unit impulse, COEF[0] = 1<<OUT_SHIFT and all others 0.
- REQ-007 Derived widths: CH_W = max(1, clog2(CHANNELS)); ACC_W = DATA_W + COEF_W + clog2(TAPS).
- REQ-008 Clock and reset are decided: one clock; reset is asynchronous and active-low.
- REQ-009 s_axis_aclk  in  1  sole clock, rising edge.
- REQ-010 s_axis_arstn  in  1  asynchronous active-low reset.
- REQ-011 s_axis_tdata  in  32  input sample; bits above DATA_W are ignored.
- REQ-012 s_axis_tvalid  in  1, and s_axis_tready  out  1: input handshake.
- REQ-013 s_axis_tuser  in  CH_W  channel id of the input sample.
- REQ-014 m_axis_tdata  out  32  filtered result.
- REQ-015 m_axis_tvalid  out  1, and m_axis_tready  in  1: output handshake.
- REQ-016 m_axis_tuser  out  CH_W  channel id of the result.

Function
- REQ-017 The state machine SHALL have four states: CLEAR, IDLE, MAC, HOLD.
- REQ-018 CLEAR SHALL write zero to all CHANNELS*TAPS delay entries, one per cycle, then go to IDLE.
- REQ-019 s_axis_tready SHALL equal (state==IDLE) && !m_axis_tvalid.
- REQ-020 On an accepted beat with s_axis_tuser < CHANNELS:
  - write the sample at that channel's head pointer;
  - latch the channel id;
  - go to MAC.
- REQ-021 On an accepted beat with s_axis_tuser >= CHANNELS, the sample SHALL be discarded, with no state or memory change and no output.
- REQ-022 Each channel SHALL keep its own circular head pointer. The pointer advances after the write and wraps from TAPS-1 to 0.
- REQ-023 MAC SHALL run exactly TAPS accumulate steps: acc += x[n-k]*COEF[k] for k = 0..TAPS-1, with read address (head-k) mod TAPS inside the channel's region.
- REQ-024 Products SHALL be full-width signed, and the accumulator SHALL be ACC_W bits with no intermediate overflow.
- REQ-025 m_axis_tvalid SHALL rise exactly TAPS+3 rising edges after the acceptance edge; the FSM is then in HOLD.
- REQ-026 m_axis_tdata SHALL be (acc >>> OUT_SHIFT) truncated to 32 bits, subject to REQ-033/034.
- REQ-027 m_axis_tuser SHALL be the latched channel id.
- REQ-028 While m_axis_tvalid && !m_axis_tready, m_axis_tdata and m_axis_tuser SHALL hold stable.
- REQ-029 On the m_axis_tvalid && m_axis_tready edge:
  - m_axis_tvalid drops;
  - the accumulator clears;
  - the FSM returns to IDLE, so s_axis_tready is high on the next cycle.
- REQ-030 Channels SHALL be fully isolated: history of channel a never contributes to the output of channel b.

Reset
- REQ-031 Reset assertion SHALL asynchronously force:
  - state = CLEAR;
  - m_axis_tvalid = 0, s_axis_tready = 0;
  - m_axis_tdata = 0, m_axis_tuser = 0;
  - accumulator = 0;
  - all head pointers = 0.
- REQ-032 Reset asserted mid-MAC or in HOLD SHALL abandon the result. After release, CLEAR SHALL run the full CHANNELS*TAPS cycles before s_axis_tready can rise.

Configuration
- REQ-033 With macro LOWPASS_FIR_SATURATE_EN defined, the shifted accumulator SHALL saturate to [-2^31, 2^31-1].
- REQ-034 Without LOWPASS_FIR_SATURATE_EN, the output SHALL be plain two's-complement truncation to 32 bits, and no saturation logic is built.

Structure
- REQ-035 Package fir_pkg SHALL hold:
  - state enum fir_state_t;
  - FIR_DEFAULT_COEF generator function;
  - the width helper for CH_W and ACC_W.
- REQ-036 Sub-module fir_delay_ram SHALL be a single-port, CHANNELS*TAPS x DATA_W synchronous RAM with one-cycle read latency, inferable as block RAM.

Verification
- REQ-037 Reset-to-ready: after reset release with CHANNELS=4, TAPS=128, s_axis_tready SHALL stay 0 for 512 cycles, then become 1.
- REQ-038 Taps: with TAPS=4, COEF={65536,131072,0,-65536} and OUT_SHIFT=16, inputs on channel 1 of 100, 0, 0, 0, 0 SHALL produce outputs 100, 200, 0, -100, 0, each with m_axis_tuser=1 and m_axis_tvalid exactly 7 edges after acceptance.
- REQ-039 Channel isolation: interleave an impulse of 100 on channel 0 with a constant 50 on channel 2, using default COEF. The outputs SHALL be channel 0: 100, 0, 0, ... and channel 2: 50, 50, ....
- REQ-040 Saturation: OUT_SHIFT=0, all COEF=8388607, constant input 8388607.
  - With the macro defined, the output SHALL be 2147483647.
  - Without the macro, the output SHALL be the low 32 bits of the exact sum.
- REQ-041 Backpressure and reset: hold m_axis_tready=0 for 20 cycles in HOLD.
  - tdata and tuser SHALL remain stable and s_axis_tready SHALL remain 0.
  - Then assert s_axis_arstn mid-MAC: m_axis_tvalid SHALL be 0 immediately, and the first post-CLEAR output SHALL use zero history.
- REQ-042 Invalid channel: s_axis_tuser=5 with CHANNELS=4 SHALL be accepted, produce no output, and leave s_axis_tready high on the next cycle.
